// File: rtl/amplitude_ram_cofactor.sv
// Amplitude state RAM behind the cofactor update stage: 1-cycle reads with write-first
// forwarding, an INIT sweep loading |0...0>, and a DUMP sweep. Option: AMP_DUMP_SKIP_ZERO_EN.
module amplitude_ram_cofactor #(
    parameter int num_qubit   = 4,
    parameter int complex_bit = 24,
    parameter int frac_bit    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_start,
    input  logic                     dump_start,
    input  logic [num_qubit-1:0]     rd_address,
    input  logic                     rd_en,
    output logic [2*complex_bit-1:0] ram_amplitude_readout,
    input  logic [2*complex_bit-1:0] wr_data,
    input  logic                     wr_en,
    input  logic [num_qubit-1:0]     wr_address,
    output logic [2*complex_bit-1:0] dump_data,
    output logic [num_qubit-1:0]     dump_address,
    output logic                     dump_valid,
    output logic                     dump_last,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << num_qubit;
    localparam int W     = 2 * complex_bit;
    localparam logic [complex_bit-1:0] ONE_FX    = complex_bit'(1) << frac_bit;
    localparam logic [W-1:0]           INIT_WORD = {ONE_FX, {complex_bit{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_INIT,
        S_DUMP
    } state_t;

    state_t             r_state;
    logic [num_qubit:0] r_cnt;
    logic [W-1:0]       r_mem [DEPTH];

    logic [num_qubit:0]   w_cnt_next;
    logic                 w_ext;
    logic                 w_mem_we;
    logic [num_qubit-1:0] w_mem_addr;
    logic [W-1:0]         w_mem_data;
    logic [W-1:0]         w_dump_word;
    logic                 w_beat_valid;
    logic                 w_beat_last;

    assign w_cnt_next  = r_cnt + (num_qubit + 1)'(1);
    assign w_ext       = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_dump_word = r_mem[r_cnt[num_qubit-1:0]];

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_address;
        w_mem_data = wr_data;
        if (r_state == S_INIT) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt[num_qubit-1:0];
            w_mem_data = (r_cnt == '0) ? INIT_WORD : '0;
        end else if (w_ext && wr_en) begin
            w_mem_we = 1'b1;
        end
    end

`ifdef AMP_DUMP_SKIP_ZERO_EN
    // Per-entry nonzero flags let the sweep know whether any later beat remains for dump_last.
    logic [DEPTH-1:0] r_nz;
    logic [DEPTH-1:0] w_above;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
            r_nz[w_mem_addr]  <= |w_mem_data;
        end
    end

    assign w_above      = ~((DEPTH'(2) << r_cnt[num_qubit-1:0]) - DEPTH'(1));
    assign w_beat_valid = |w_dump_word;
    assign w_beat_last  = w_beat_valid && !(|(r_nz & w_above));
`else
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    assign w_beat_valid = 1'b1;
    assign w_beat_last  = w_cnt_next[num_qubit];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state               <= S_IDLE;
            r_cnt                 <= '0;
            ram_amplitude_readout <= '0;
            dump_data             <= '0;
            dump_address          <= '0;
            dump_valid            <= 1'b0;
            dump_last             <= 1'b0;
            busy                  <= 1'b0;
            wr_drop               <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (rd_en) begin
                        ram_amplitude_readout <= (wr_en && (wr_address == rd_address)) ?
                                                 wr_data : r_mem[rd_address];
                    end
                    if (init_start) begin
                        r_state <= S_INIT;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        wr_drop <= 1'b0;
                    end else if (dump_start) begin
                        r_state <= S_DUMP;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end else if (rd_en || wr_en) begin
                        r_state <= S_RUN;
                    end
                end
                S_INIT: begin
                    if (wr_en) wr_drop <= 1'b1;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next[num_qubit]) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_DUMP: begin
                    if (wr_en) wr_drop <= 1'b1;
                    dump_data    <= w_dump_word;
                    dump_address <= r_cnt[num_qubit-1:0];
                    dump_valid   <= w_beat_valid;
                    dump_last    <= w_beat_last;
                    r_cnt        <= w_cnt_next;
                    if (w_cnt_next[num_qubit]) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amplitude_ram_cofactor.sv
// Scoreboard bench for amplitude_ram_cofactor: a plain-array reference memory produces
// expected reads and dump beats; negedge monitors pop and compare.
module tb_amplitude_ram_cofactor;

    localparam int NQ = 4;
    localparam int CB = 24;
    localparam int FB = 16;
    localparam int W  = 2 * CB;
    localparam int D  = 1 << NQ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_start = 1'b0;
    logic          dump_start = 1'b0;
    logic [NQ-1:0] rd_address = '0;
    logic          rd_en = 1'b0;
    logic [W-1:0]  ram_amplitude_readout;
    logic [W-1:0]  wr_data = '0;
    logic          wr_en = 1'b0;
    logic [NQ-1:0] wr_address = '0;
    logic [W-1:0]  dump_data;
    logic [NQ-1:0] dump_address;
    logic          dump_valid;
    logic          dump_last;
    logic          busy;
    logic          wr_drop;

    amplitude_ram_cofactor #(
        .num_qubit  (NQ),
        .complex_bit(CB),
        .frac_bit   (FB)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .init_start           (init_start),
        .dump_start           (dump_start),
        .rd_address           (rd_address),
        .rd_en                (rd_en),
        .ram_amplitude_readout(ram_amplitude_readout),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .wr_address           (wr_address),
        .dump_data            (dump_data),
        .dump_address         (dump_address),
        .dump_valid           (dump_valid),
        .dump_last            (dump_last),
        .busy                 (busy),
        .wr_drop              (wr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [NQ-1:0] a;
        logic          l;
    } beat_t;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] ref_mem [D];
    logic [W-1:0] rd_q [$];
    beat_t        dump_q [$];
    logic         rd_pend = 1'b0;
    logic         tb_accept = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= rd_en && tb_accept && !rst;

    always @(negedge clk) begin
        logic [W-1:0] e;
        beat_t        b;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL readout_extra: got %h, required no pending read", ram_amplitude_readout);
            end else begin
                e = rd_q.pop_front();
                chk("readout", ram_amplitude_readout, e);
            end
        end
        if (dump_valid) begin
            if (dump_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL dump_extra: got beat at addr %0d, required none", dump_address);
            end else begin
                b = dump_q.pop_front();
                chk("dump_address", dump_address, b.a);
                chk("dump_data", dump_data, b.d);
                chk("dump_last", dump_last, b.l);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic rd, input logic [NQ-1:0] ra,
                          input logic wr, input logic [NQ-1:0] wa, input logic [W-1:0] wd);
        rd_en = rd; rd_address = ra; wr_en = wr; wr_address = wa; wr_data = wd;
        if (rd) rd_q.push_back((wr && wa == ra) ? wd : ref_mem[ra]);
        if (wr) ref_mem[wa] = wd;
        step();
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic do_init();
        int n;
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("init_busy_cycles", n, 16);
        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        ref_mem[0] = {24'h010000, 24'h000000};
    endtask

    task automatic do_dump(input bit inject);
        int    n;
        int    last_i;
        beat_t b;
        logic [W-1:0] hold;
        last_i = -1;
        for (int i = 0; i < D; i++) begin
`ifdef AMP_DUMP_SKIP_ZERO_EN
            if (ref_mem[i] != '0) last_i = i;
`else
            last_i = i;
`endif
        end
        for (int i = 0; i < D; i++) begin
`ifdef AMP_DUMP_SKIP_ZERO_EN
            if (ref_mem[i] == '0) continue;
`endif
            b.d = ref_mem[i];
            b.a = NQ'(i);
            b.l = (i == last_i);
            dump_q.push_back(b);
        end
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            if (inject && n == 3) begin
                hold = ram_amplitude_readout;
                tb_accept = 1'b0;
                rd_en = 1'b1; rd_address = 4'd3;
                wr_en = 1'b1; wr_address = 4'd3; wr_data = 48'h7E57AB_CD0123;
                step();
                rd_en = 1'b0; wr_en = 1'b0;
                tb_accept = 1'b1;
                chk("wr_drop_set", wr_drop, 1'b1);
                chk("readout_hold_in_dump", ram_amplitude_readout, hold);
            end else begin
                step();
            end
            n++;
        end
        chk("dump_busy_cycles", n, 16);
        step();
        step();
        chk("dump_beats_outstanding", dump_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         rd, wr;
        logic [NQ-1:0] ra, wa;
        logic [W-1:0] wd;

        for (int i = 0; i < D; i++) ref_mem[i] = '0;
        step(); step(); step();
        chk("rst_readout", ram_amplitude_readout, '0);
        chk("rst_dump_data", dump_data, '0);
        chk("rst_dump_address", dump_address, '0);
        chk("rst_dump_valid", dump_valid, 1'b0);
        chk("rst_dump_last", dump_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_drop", wr_drop, 1'b0);
        rst = 1'b0;
        step();

        do_init();
        for (int i = 0; i < D; i++) access(1'b1, NQ'(i), 1'b0, '0, '0);

        access(1'b0, '0, 1'b1, 4'd5, 48'h00C000_FF4000);
        access(1'b1, 4'd5, 1'b0, '0, '0);
        access(1'b1, 4'd9, 1'b1, 4'd9, 48'h000100_000200);
        access(1'b1, 4'd9, 1'b0, '0, '0);
        step();

        do_dump(1'b1);
        chk("wr_drop_sticky", wr_drop, 1'b1);
        access(1'b1, 4'd3, 1'b0, '0, '0);
        do_init();
        chk("wr_drop_cleared", wr_drop, 1'b0);

        for (int k = 0; k < 300; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            ra = NQ'($urandom_range(0, D - 1));
            wa = ($urandom_range(0, 3) == 0) ? ra : NQ'($urandom_range(0, D - 1));
            wd = ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom};
            access(rd, ra, wr, wa, wd);
        end
        step();
        do_dump(1'b0);

        for (int i = 0; i < D; i++) access(1'b0, '0, 1'b1, NQ'(i), {16'hA5A5, 28'h0, 4'(i)} | 48'h1);
        init_start = 1'b1;
        step();
        init_start = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midinit_busy", busy, 1'b0);
        chk("midinit_dump_valid", dump_valid, 1'b0);
        chk("midinit_readout", ram_amplitude_readout, '0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("after_rst_busy", busy, 1'b0);
        for (int i = 8; i < D; i++) access(1'b1, NQ'(i), 1'b0, '0, '0);
        step();
        step();
        chk("reads_outstanding", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
